alu_sched: RTL
==============

# alu_sched

Two-requester scheduler and power sequencer for the 16-bit multi-cycle ALU. It arbitrates operation requests round-robin and powers the ALU up on demand (power enable first, isolation released later). It launches each operation with a one-cycle start pulse, holds the operands until the ALU is no longer busy, returns the tagged result, and gates the ALU off after an idle period. It sits between the two datapath clients and the ALU's `alu_pwr_en`/`iso_en`/`start`/`busy` interface.

## Interface
- `PWR_UP_CYCLES`, default 4: cycles `alu_pwr_en` is high with isolation still on before release; legal range ≥1.
- `IDLE_PD_CYCLES`, default 16: consecutive idle READY cycles before power-down; legal range ≥1.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid`/`req1_valid` in 1: request valid. Valid and payload must be held stable until ready.
- `req0_ready`/`req1_ready` out 1: request accepted this cycle (combinational, from state and arbiter).
- `req0_a`/`req1_a`, `req0_b`/`req1_b` in 16: operands.
- `req0_op`/`req1_op` in 4: ALU opcode, passed through unchanged.
- `rsp_valid` out 1: one-cycle result pulse; no backpressure.
- `rsp_id` out 1: requester index of the result.
- `rsp_result` out 16: result.
- `alu_pwr_en`, `iso_en` out 1: ALU power enable and isolation controls.
- `alu_a`, `alu_b` out 16: operands driven to the ALU.
- `alu_opcode` out 4: opcode driven to the ALU.
- `alu_start` out 1: start pulse to the ALU.
- `alu_busy` in 1: ALU busy.
- `alu_result` in 16: ALU result.

## Operation
- States: OFF, PWR_UP, ISO_REL, READY, START, WAIT, ISO_ON.
- **OFF:** `alu_pwr_en=0`, `iso_en=1`. Either valid → PWR_UP with the counter at 0.
- **PWR_UP:** `alu_pwr_en=1`, `iso_en=1`. Counter increments; at `PWR_UP_CYCLES-1` → ISO_REL.
- **ISO_REL:** `alu_pwr_en=1`, `iso_en=0` → READY.
- **READY:** power on, isolation off.
  - Any valid: the arbiter grants one requester and its ready is high. Operands, opcode and id are registered into `alu_a/alu_b/alu_opcode` → START. The idle counter clears.
  - No valid: the idle counter increments; at `IDLE_PD_CYCLES-1` → ISO_ON.
- **START:** `alu_start=1` for exactly this cycle → WAIT.
- **WAIT:** operands are held. On the first cycle with `alu_busy=0`, register `rsp_result<=alu_result`, `rsp_id`, and `rsp_valid<=1` → READY. `rsp_valid` is therefore high in the first READY cycle, and a new grant may occur in that same cycle.
- **ISO_ON:** `alu_pwr_en=1`, `iso_en=1` → OFF. A valid seen in ISO_ON is not accepted; it is served via OFF→PWR_UP.
- **Arbitration:** 2-way round-robin. With both valid, grant the requester not granted last. `last_grant` resets to 1, so req0 wins first. Ready is never high outside READY, and never high for both requesters.
- **Opcodes:** 1010–1111 are forwarded unchanged; the ALU returns 0 for them.
- **Reset:** in any state, reset → OFF. All outputs go to 0 except `iso_en=1`; counters clear and `last_grant=1`. An in-flight operation is dropped with no response.

## Timing
- Latencies are counted from the accept cycle T (READY with ready high) to `rsp_valid`:
  - Single-cycle ops (0000–0111 and undefined opcodes): T+3.
  - MUL (1000): T+8 (busy observed T+2..T+6).
  - DIV (1001): T+12 (busy observed T+2..T+10).
- Cold start: valid first seen in OFF at cycle 0 → accept at cycle `PWR_UP_CYCLES+2` (6 at the default).
- After an accept, the earliest possible next accept is the cycle `rsp_valid` is high.

## Configuration
- `ALU_SCHED_AUTO_PD_EN` defined: the idle counter and ISO_ON path are active, as described above.
- `ALU_SCHED_AUTO_PD_EN` undefined: READY never leaves on idle. After the first power-up the ALU stays powered and de-isolated until reset; the idle counter is not built.

## Structure
- Package `alu_sched_pkg` holds:
  - the state enum;
  - opcode constants `OP_MUL=4'b1000` and `OP_DIV=4'b1001`;
  - the 4-bit opcode typedef.
- Sub-module `alu_rr_arb`: 2-way round-robin arbiter with inputs `valid[1:0]`, `en` and `last_grant`, and outputs `grant[1:0]` (one-hot or zero).

## Test plan
- Reset, then req0 ADD A=3 B=5 from OFF, defaults → `alu_pwr_en` rises at cycle 1, `iso_en` falls at cycle 5, accept at cycle 6, `rsp_valid` at 9 with result 8 and id 0.
- Powered, req1 MUL A=7 B=6 → `alu_start` one pulse at T+1, operands held through WAIT, rsp at T+8 with result 42 and id 1.
- Both valid continuously with DIV 100/7 on req0 and ADD on req1 → grants alternate 0,1,0,1. Responses are 14 at accept+12 for req0, and the sum at accept+3 for req1.
- No requests for 16 READY cycles → ISO_ON (`iso_en=1`, `pwr_en=1`), then OFF. A request during ISO_ON is accepted only after the full re-power sequence.
- `rst` pulsed during MUL WAIT → next cycle OFF, `iso_en=1`, no `rsp_valid`. A pending request is served after a fresh power-up.
- Build without `ALU_SCHED_AUTO_PD_EN`, idle 100 cycles → `alu_pwr_en` stays 1 and `iso_en` stays 0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU scheduler / power sequencer.
package alu_sched_pkg;

  localparam int DATA_W  = 16;
  localparam int NUM_REQ = 2;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_MUL = 4'b1000;
  localparam opcode_t OP_DIV = 4'b1001;

  typedef enum logic [2:0] {
    OFF,
    PWR_UP,
    ISO_REL,
    READY,
    START,
    WAIT,
    ISO_ON
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    opcode_t           op;
  } alu_req_t;

endpackage

// File: rtl/alu_rr_arb.sv
// 2-way round-robin arbiter: with both valid, the requester not granted last wins.
module alu_rr_arb (
  input  logic [1:0] valid,
  input  logic       en,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (&valid) grant = last_grant ? 2'b01 : 2'b10;
      else        grant = valid;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Two-requester scheduler and power sequencer for the multi-cycle ALU.
// Idle power-down is built only when ALU_SCHED_AUTO_PD_EN is defined.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int PWR_UP_CYCLES  = 4,
  parameter int IDLE_PD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  opcode_t           req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  opcode_t           req1_op,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              alu_pwr_en,
  output logic              iso_en,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output opcode_t           alu_opcode,
  output logic              alu_start,
  input  logic              alu_busy,
  input  logic [DATA_W-1:0] alu_result
);

  if (PWR_UP_CYCLES < 1 || IDLE_PD_CYCLES < 1) begin : g_param_chk
    $error("alu_sched: PWR_UP_CYCLES and IDLE_PD_CYCLES must be >= 1");
  end

  localparam int PU_W = (PWR_UP_CYCLES > 1) ? $clog2(PWR_UP_CYCLES) : 1;
  localparam logic [PU_W-1:0] PU_LAST = PU_W'(PWR_UP_CYCLES - 1);

  state_e                    state, state_nx;
  logic [PU_W-1:0]           pu_cnt;
  logic                      last_grant;
  logic                      arb_en;
  logic                      idle_done;
  logic [NUM_REQ-1:0]        valid, grant;
  alu_req_t [NUM_REQ-1:0]    req;
  alu_req_t                  gnt_req;

  assign valid   = {req1_valid, req0_valid};
  assign req[0]  = {req0_a, req0_b, req0_op};
  assign req[1]  = {req1_a, req1_b, req1_op};
  assign gnt_req = req[grant[1]];
  assign {req1_ready, req0_ready} = grant;

  alu_rr_arb u_arb (
    .valid      (valid),
    .en         (arb_en),
    .last_grant (last_grant),
    .grant      (grant)
  );

`ifdef ALU_SCHED_AUTO_PD_EN
  localparam int IC_W = (IDLE_PD_CYCLES > 1) ? $clog2(IDLE_PD_CYCLES) : 1;
  localparam logic [IC_W-1:0] IC_LAST = IC_W'(IDLE_PD_CYCLES - 1);

  logic [IC_W-1:0] idle_cnt;

  // Counts only consecutive idle READY cycles; any other state restarts it.
  always_ff @(posedge clk) begin
    if (rst || state != READY || |valid) idle_cnt <= '0;
    else                                  idle_cnt <= idle_cnt + 1'b1;
  end

  assign idle_done = (state == READY) && !(|valid) && (idle_cnt == IC_LAST);
`else
  assign idle_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= OFF;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    alu_pwr_en = 1'b1;
    iso_en     = 1'b0;
    alu_start  = 1'b0;
    arb_en     = 1'b0;
    case (state)
      OFF: begin
        alu_pwr_en = 1'b0;
        iso_en     = 1'b1;
        if (|valid) state_nx = PWR_UP;
      end
      PWR_UP: begin
        iso_en = 1'b1;
        if (pu_cnt == PU_LAST) state_nx = ISO_REL;
      end
      ISO_REL: state_nx = READY;
      READY: begin
        arb_en = 1'b1;
        if (|valid)         state_nx = START;
        else if (idle_done) state_nx = ISO_ON;
      end
      START: begin
        alu_start = 1'b1;
        state_nx  = WAIT;
      end
      WAIT: if (!alu_busy) state_nx = READY;
      ISO_ON: begin
        iso_en   = 1'b1;
        state_nx = OFF;
      end
      default: begin
        alu_pwr_en = 1'b0;
        iso_en     = 1'b1;
        state_nx   = OFF;
      end
    endcase
  end

  // last_grant doubles as the id of the operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pu_cnt     <= '0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == OFF)         pu_cnt <= '0;
      else if (state == PWR_UP) pu_cnt <= pu_cnt + 1'b1;
      if (|grant) begin
        alu_a      <= gnt_req.a;
        alu_b      <= gnt_req.b;
        alu_opcode <= gnt_req.op;
        last_grant <= grant[1];
      end
      if (state == WAIT && !alu_busy) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= last_grant;
        rsp_result <= alu_result;
      end
    end
  end

endmodule
